// File: rtl/lspc_pkg.sv
// ============================================================================
// Module      : lspc_pkg
// Description : Shared bit indices for the LSPC timer / IRQ slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lspc_pkg;

  localparam int ACK_RESET = 0;
  localparam int ACK_VBL   = 1;
  localparam int ACK_TIMER = 2;

  localparam int TM_RELOAD_WR   = 0;
  localparam int TM_RELOAD_VBL  = 1;
  localparam int TM_RELOAD_ZERO = 2;

  typedef logic [2:0] timer_mode_t;

endpackage : lspc_pkg

`default_nettype wire

// File: rtl/lspc_irq_flag.sv
// ============================================================================
// Module      : lspc_irq_flag
// Description : One pending-interrupt flag; set dominates clear, output is
//               the registered flag inverted (active-low request).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lspc_irq_flag #(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic set_i,
  input  logic clr_i,
  output logic irq_no
);

  logic pend_q;
  logic pend_d;

  always_comb begin
    pend_d = set_i | (pend_q & ~clr_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= RESET_VAL;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign irq_no = ~pend_q;

endmodule : lspc_irq_flag

`default_nettype wire

// File: rtl/lspc_timer_irq.sv
// ============================================================================
// Module      : lspc_timer_irq
// Description : LSPC raster timer (pixel-rate down-counter with reload) and
//               the VBL / timer / reset pending-interrupt lines.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lspc_timer_irq
  import lspc_pkg::*;
#(
  parameter int TIMER_W          = 32,
  parameter bit RESET_IRQ_AT_POR = 1'b1
) (
  input  logic               CLK_24M,
  input  logic               RESET,
  input  logic               PIXEL_EN,
  input  logic               VBLANK_START,
  input  logic               PAL_STOP_ZONE,
  input  logic [15:0]        M68K_DATA,
  input  logic               WR_TIMER_HIGH,
  input  logic               WR_TIMER_LOW,
  input  logic               WR_IRQ_ACK,
  input  logic [2:0]         TIMER_MODE,
  input  logic               TIMER_IRQ_EN,
  input  logic               TIMER_STOP,
  output logic [TIMER_W-1:0] TIMER_COUNT,
  output logic               nIRQ_VBL,
  output logic               nIRQ_TIMER,
  output logic               nIRQ_RESET
);

  localparam int HI_W = TIMER_W - 16;

  logic               wr_hi_q, wr_lo_q, wr_ack_q;
  logic               hi_commit, lo_commit, ack_commit;
  logic [TIMER_W-1:0] count_q, count_d;
  logic [TIMER_W-1:0] reload_q, reload_d;
  logic               tick;
  logic               timer_evt;
  timer_mode_t        mode;

  assign mode = TIMER_MODE;

  // A commit is the first low cycle of a strobe: holding it low never re-fires.
  assign hi_commit  = ~WR_TIMER_HIGH & wr_hi_q;
  assign lo_commit  = ~WR_TIMER_LOW  & wr_lo_q;
  assign ack_commit = ~WR_IRQ_ACK    & wr_ack_q;

  assign tick      = PIXEL_EN & ~(TIMER_STOP & PAL_STOP_ZONE);
  assign timer_evt = tick & (count_q == '0);

  always_comb begin
    reload_d = reload_q;
    count_d  = count_q;

    if (hi_commit) begin
      reload_d[TIMER_W-1:16] = HI_W'(M68K_DATA);
    end
    if (lo_commit) begin
      reload_d[15:0] = M68K_DATA;
    end

    // Low-write reload beats vblank reload beats the pixel tick.
    if (lo_commit && mode[TM_RELOAD_WR]) begin
      count_d = {reload_q[TIMER_W-1:16], M68K_DATA};
    end else if (VBLANK_START && mode[TM_RELOAD_VBL]) begin
      count_d = reload_q;
    end else if (tick) begin
      if (count_q == '0) begin
        count_d = mode[TM_RELOAD_ZERO] ? reload_q : '1;
      end else begin
        count_d = count_q - TIMER_W'(1);
      end
    end
  end

  always_ff @(posedge CLK_24M or negedge RESET) begin
    if (!RESET) begin
      wr_hi_q  <= 1'b1;
      wr_lo_q  <= 1'b1;
      wr_ack_q <= 1'b1;
      count_q  <= '0;
      reload_q <= '0;
    end else begin
      wr_hi_q  <= WR_TIMER_HIGH;
      wr_lo_q  <= WR_TIMER_LOW;
      wr_ack_q <= WR_IRQ_ACK;
      count_q  <= count_d;
      reload_q <= reload_d;
    end
  end

  assign TIMER_COUNT = count_q;

  lspc_irq_flag #(.RESET_VAL(1'b0)) u_flag_vbl (
    .clk_i  (CLK_24M),
    .rst_ni (RESET),
    .set_i  (VBLANK_START),
    .clr_i  (ack_commit & M68K_DATA[ACK_VBL]),
    .irq_no (nIRQ_VBL)
  );

  lspc_irq_flag #(.RESET_VAL(1'b0)) u_flag_timer (
    .clk_i  (CLK_24M),
    .rst_ni (RESET),
    .set_i  (timer_evt & TIMER_IRQ_EN),
    .clr_i  (ack_commit & M68K_DATA[ACK_TIMER]),
    .irq_no (nIRQ_TIMER)
  );

  lspc_irq_flag #(.RESET_VAL(RESET_IRQ_AT_POR)) u_flag_reset (
    .clk_i  (CLK_24M),
    .rst_ni (RESET),
    .set_i  (1'b0),
    .clr_i  (ack_commit & M68K_DATA[ACK_RESET]),
    .irq_no (nIRQ_RESET)
  );

endmodule : lspc_timer_irq

`default_nettype wire

// File: tb/tb_lspc_timer_irq.sv
// ============================================================================
// Module      : tb_lspc_timer_irq
// Description : Directed self-checking bench for lspc_timer_irq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lspc_timer_irq;

  logic        clk;
  logic        rst_n;
  logic        pixel_en;
  logic        vblank_start;
  logic        pal_stop_zone;
  logic [15:0] data;
  logic        wr_hi;
  logic        wr_lo;
  logic        wr_ack;
  logic [2:0]  mode;
  logic        irq_en;
  logic        stop;
  logic [31:0] count;
  logic        n_vbl;
  logic        n_timer;
  logic        n_reset;

  int n_checks;
  int n_fails;

  lspc_timer_irq #(
    .TIMER_W          (32),
    .RESET_IRQ_AT_POR (1'b1)
  ) dut (
    .CLK_24M       (clk),
    .RESET         (rst_n),
    .PIXEL_EN      (pixel_en),
    .VBLANK_START  (vblank_start),
    .PAL_STOP_ZONE (pal_stop_zone),
    .M68K_DATA     (data),
    .WR_TIMER_HIGH (wr_hi),
    .WR_TIMER_LOW  (wr_lo),
    .WR_IRQ_ACK    (wr_ack),
    .TIMER_MODE    (mode),
    .TIMER_IRQ_EN  (irq_en),
    .TIMER_STOP    (stop),
    .TIMER_COUNT   (count),
    .nIRQ_VBL      (n_vbl),
    .nIRQ_TIMER    (n_timer),
    .nIRQ_RESET    (n_reset)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after a rising edge; outputs are sampled there too.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      pixel_en = 1'b1;
      cyc(1);
      pixel_en = 1'b0;
      cyc(3);
    end
  endtask

  task automatic wr_high(input logic [15:0] d);
    wr_hi = 1'b0; data = d; cyc(1);
    wr_hi = 1'b1; cyc(1);
  endtask

  task automatic wr_low(input logic [15:0] d);
    wr_lo = 1'b0; data = d; cyc(1);
    wr_lo = 1'b1; cyc(1);
  endtask

  task automatic ack(input logic [15:0] d);
    wr_ack = 1'b0; data = d; cyc(1);
    wr_ack = 1'b1; cyc(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_checks = 0; n_fails = 0;
    rst_n = 1'b0; pixel_en = 1'b0; vblank_start = 1'b0; pal_stop_zone = 1'b0;
    data = 16'h0; wr_hi = 1'b1; wr_lo = 1'b1; wr_ack = 1'b1;
    mode = 3'b000; irq_en = 1'b0; stop = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(1);

    check("por_count",   count,          32'h0);
    check("por_nreset",  {31'b0, n_reset}, 32'h0);
    check("por_nvbl",    {31'b0, n_vbl},   32'h1);
    check("por_ntimer",  {31'b0, n_timer}, 32'h1);
    ack(16'h0001);
    check("por_ack_nreset", {31'b0, n_reset}, 32'h1);

    // Reload on write + reload on zero: events every 4 ticks
    mode = 3'b101; irq_en = 1'b1;
    wr_high(16'h0000);
    wr_low(16'h0003);
    check("rw_load", count, 32'h3);
    tick(3);
    check("rw_3ticks_cnt",  count, 32'h0);
    check("rw_3ticks_irq",  {31'b0, n_timer}, 32'h1);
    tick(1);
    check("rw_4ticks_irq",  {31'b0, n_timer}, 32'h0);
    check("rw_4ticks_cnt",  count, 32'h3);
    ack(16'h0004);
    check("rw_ack",         {31'b0, n_timer}, 32'h1);
    tick(3);
    check("rw_2nd_pre",     {31'b0, n_timer}, 32'h1);
    tick(1);
    check("rw_2nd_irq",     {31'b0, n_timer}, 32'h0);
    check("rw_2nd_cnt",     count, 32'h3);
    ack(16'h00FB);
    check("rw_ack_other_bits", {31'b0, n_timer}, 32'h0);
    ack(16'h0004);

    // No auto-reload: wrap to all-ones
    mode = 3'b001;
    wr_low(16'h0001);
    check("wrap_load", count, 32'h1);
    tick(2);
    check("wrap_cnt", count, 32'hFFFF_FFFF);
    check("wrap_irq", {31'b0, n_timer}, 32'h0);
    ack(16'h0004);
    irq_en = 1'b0;
    wr_low(16'h0001);
    tick(2);
    check("wrap_noen_cnt", count, 32'hFFFF_FFFF);
    check("wrap_noen_irq", {31'b0, n_timer}, 32'h1);

    // Vblank reload and set-beats-ack
    mode = 3'b010;
    wr_high(16'h0000);
    wr_low(16'h0100);
    check("vbl_no_wr_load", count, 32'hFFFF_FFFF);
    vblank_start = 1'b1; cyc(1);
    vblank_start = 1'b0;
    check("vbl_cnt",  count, 32'h0000_0100);
    check("vbl_irq",  {31'b0, n_vbl}, 32'h0);
    cyc(1);
    wr_ack = 1'b0; data = 16'h0002; vblank_start = 1'b1; cyc(1);
    wr_ack = 1'b1; vblank_start = 1'b0; cyc(1);
    check("vbl_set_wins", {31'b0, n_vbl}, 32'h0);
    ack(16'h0002);
    check("vbl_ack", {31'b0, n_vbl}, 32'h1);

    // Stop zone holds the counter but not writes
    mode = 3'b000; stop = 1'b1; pal_stop_zone = 1'b1;
    tick(20);
    check("stop_hold", count, 32'h0000_0100);
    mode = 3'b001;
    wr_low(16'h0055);
    check("stop_wr_load", count, 32'h0000_0055);
    pal_stop_zone = 1'b0;
    tick(1);
    check("stop_release_tick", count, 32'h0000_0054);
    stop = 1'b0;

    // Strobe held low 10 cycles with changing data: single commit
    wr_lo = 1'b0; data = 16'h0011; cyc(1);
    for (int i = 0; i < 9; i++) begin
      data = 16'h0020 + 16'(i);
      cyc(1);
    end
    check("hold_one_commit", count, 32'h0000_0011);
    wr_lo = 1'b1; cyc(1);
    check("hold_after_release", count, 32'h0000_0011);

    // Mid-run reset with a write strobe still low
    vblank_start = 1'b1; cyc(1);
    vblank_start = 1'b0;
    check("mr_vbl_pre", {31'b0, n_vbl}, 32'h0);
    rst_n = 1'b0; wr_lo = 1'b0; data = 16'h0022;
    #5;
    check("mr_count",  count, 32'h0);
    check("mr_nreset", {31'b0, n_reset}, 32'h0);
    check("mr_nvbl",   {31'b0, n_vbl},   32'h1);
    check("mr_ntimer", {31'b0, n_timer}, 32'h1);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    check("mr_commit_after_release", count, 32'h0000_0022);
    data = 16'h0033;
    cyc(3);
    check("mr_no_recommit", count, 32'h0000_0022);
    wr_lo = 1'b1; cyc(1);
    ack(16'h0001);
    check("mr_ack_nreset", {31'b0, n_reset}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_lspc_timer_irq

`default_nettype wire

// File: doc/lspc_timer_irq.md
# lspc_timer_irq

Raster timer and interrupt-pending unit of the LSPC, directly downstream of the LSPC register decoder. Consumes the decoder's active-low write strobes (timer high/low, IRQ acknowledge), the latched timer mode/enable/stop bits and the CPU data bus. Produces a 32-bit pixel-rate down-counter with programmable reload and the three pending-interrupt lines (VBL, timer, reset) to the 68K interrupt encoder.

## Interface
Parameters:
- TIMER_W, 32, counter and reload width
- RESET_IRQ_AT_POR, 1, reset-IRQ pending flag value on reset

Ports:
- CLK_24M  in  1  master clock; all state on rising edge
- RESET  in  1  asynchronous, active-low reset
- PIXEL_EN  in  1  one-cycle strobe every 4th CLK_24M (6 MHz pixel tick)
- VBLANK_START  in  1  one-cycle strobe at first vblank line
- PAL_STOP_ZONE  in  1  high during the lines where a stopped timer must hold
- M68K_DATA  in  16  CPU write data, valid whenever a strobe is low
- WR_TIMER_HIGH  in  1  active-low, synchronous to CLK_24M
- WR_TIMER_LOW  in  1  active-low, synchronous to CLK_24M
- WR_IRQ_ACK  in  1  active-low, synchronous to CLK_24M
- TIMER_MODE  in  3  [0] reload on low write, [1] reload at vblank, [2] reload on zero
- TIMER_IRQ_EN  in  1  timer interrupt enable
- TIMER_STOP  in  1  high: hold counter while PAL_STOP_ZONE high
- TIMER_COUNT  out  32  current counter value
- nIRQ_VBL  out  1  active-low pending VBL interrupt
- nIRQ_TIMER  out  1  active-low pending timer interrupt
- nIRQ_RESET  out  1  active-low pending reset interrupt

## Operation
- Write commit: each strobe is registered; commit fires on the single cycle where strobe is low and its registered copy is high (falling edge). M68K_DATA sampled that cycle. Held-low strobe commits exactly once.
- High commit: RELOAD[31:16] <= data. Low commit: RELOAD[15:0] <= data; if TIMER_MODE[0], COUNT <= {RELOAD[31:16], data} same cycle.
- Tick: on PIXEL_EN, unless (TIMER_STOP & PAL_STOP_ZONE):
  - COUNT != 0: COUNT <= COUNT - 1.
  - COUNT == 0: timer event; if TIMER_MODE[2] COUNT <= RELOAD, else COUNT <= all-ones (modulo wrap).
- Timer event with TIMER_IRQ_EN=1 sets timer pending; with TIMER_IRQ_EN=0 no flag set, reload/wrap still occurs.
- VBLANK_START: sets VBL pending; if TIMER_MODE[1], COUNT <= RELOAD.
- ACK commit: data[0] clears reset pending, data[1] clears VBL pending, data[2] clears timer pending; other bits ignored.
- COUNT load priority in one cycle: low-write reload > vblank reload > tick.
- Pending flag set and ack in same cycle: set wins.

## Timing
- Reset values: COUNT=0, RELOAD=0, strobe copies=1, nIRQ_VBL=1, nIRQ_TIMER=1, nIRQ_RESET = ~RESET_IRQ_AT_POR (0 by default).
- Write latency: RELOAD/COUNT updated on the edge ending the commit cycle; TIMER_COUNT visible next cycle.
- IRQ latency: nIRQ_* low on the edge ending the event cycle (registered, 1 clock); ack returns high on the edge ending the commit cycle.
- Reset mid-write: strobe copies return to 1; a strobe still low after RESET release commits once.
- Stop condition gates only ticks; writes, vblank reload and acks still act.
- Counter of RELOAD=N with mode[2] gives events every N+1 ticks.

## Structure
- Shared package lspc_pkg: ACK bit indices (ACK_RESET=0, ACK_VBL=1, ACK_TIMER=2), TIMER_MODE bit indices (TM_RELOAD_WR=0, TM_RELOAD_VBL=1, TM_RELOAD_ZERO=2).
- One sub-module lspc_irq_flag (set, clear, reset value parameter, active-low registered output), instantiated three times.
- Strobe edge detection and counter datapath live in the top module.

## Test plan
- Reset: assert RESET low mid-run -> COUNT=0, nIRQ_RESET=0, nIRQ_VBL=nIRQ_TIMER=1; ack 0x0001 -> nIRQ_RESET=1 next cycle.
- Reload-on-write: mode=3'b101, IRQ_EN=1, write high 0x0000, low 0x0003 -> COUNT=3; after 4 ticks nIRQ_TIMER=0, COUNT=3 again; events every 4 ticks.
- No auto-reload: mode=3'b001, low 0x0001 -> after 2 ticks COUNT=0xFFFFFFFF, flag set; IRQ_EN=0 repeat -> no flag.
- VBL: mode[1]=1, RELOAD=0x00000100, VBLANK_START -> COUNT=0x100, nIRQ_VBL=0; ack 0x0002 same cycle as next VBLANK_START -> nIRQ_VBL stays 0.
- Stop: TIMER_STOP=1, PAL_STOP_ZONE=1, 20 ticks -> COUNT unchanged; low write with mode[0] still loads.
- Strobe held low 10 cycles with data changing -> one commit, first-cycle data used.
